// File: rtl/jogo_pkg.sv
// Shared definitions for the memory game button path: FSM state codes,
// bus widths and small helpers used by the detector and its counters.
package jogo_pkg;

  localparam int ESTADO_W = 3;
  localparam int BOTOES_W = 4;

  typedef enum logic [ESTADO_W-1:0] {
    OCIOSO      = 3'd0,
    FILTRANDO   = 3'd1,
    PRESSIONADO = 3'd2,
    SOLTANDO    = 3'd3
  } estado_t;

  // Bits needed to hold 0..max_val; never less than one.
  function automatic int largura_cnt(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  // True when exactly one button is down.
  function automatic logic eh_um_quente(input logic [BOTOES_W-1:0] b);
    return (b != '0) && ((b & (b - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/detector_jogada_if.sv
// Player button bus between the game control unit (master) and the
// play detector (slave).
interface detector_jogada_if;
  import jogo_pkg::*;

  logic                habilita;
  logic                zera_timeout;
  logic [BOTOES_W-1:0] botoes;
  logic                jogada_feita;
  logic [BOTOES_W-1:0] jogada;
  logic                jogada_invalida;
  logic                timeout;
  logic                db_tem_jogada;
  logic [ESTADO_W-1:0] db_estado;

  modport master (
    output habilita, zera_timeout, botoes,
    input  jogada_feita, jogada, jogada_invalida, timeout, db_tem_jogada, db_estado
  );

  modport slave (
    input  habilita, zera_timeout, botoes,
    output jogada_feita, jogada, jogada_invalida, timeout, db_tem_jogada, db_estado
  );

endinterface

// File: rtl/contador_sat.sv
// Saturating up-counter with synchronous clear; o_cheio flags that the
// count sits at MAX. Clear wins over enable.
module contador_sat
  import jogo_pkg::*;
#(
  parameter int MAX = 7
) (
  input  logic clock,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_cheio
);

  localparam int             W      = largura_cnt(MAX);
  localparam logic [W-1:0]   LIMITE = W'(MAX);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != LIMITE)) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cheio = (r_cnt == LIMITE);

endmodule

// File: rtl/detector_jogada.sv
// Debounces player buttons into one jogada_feita / jogada_invalida pulse per
// press-release. Idle timeout is built only when DETECTOR_TIMEOUT_EN is defined.
module detector_jogada
  import jogo_pkg::*;
#(
  parameter int ESTAVEL = 3,
  parameter int TIMEOUT = 30000
) (
  input  logic               clock,
  input  logic               reset,
  detector_jogada_if.slave   bus
);

  estado_t             r_estado;
  estado_t             w_prox;
  logic [BOTOES_W-1:0] r_v;
  logic [BOTOES_W-1:0] r_jogada;
  logic                r_feita;
  logic                r_invalida;

  logic w_tem;
  logic w_mudou;
  logic w_cnt_cheio;
  logic w_estavel;
  logic w_dispara;
  logic w_clr_estavel;
  logic w_valida;

  assign w_tem    = (bus.botoes != '0);
  assign w_mudou  = (bus.botoes != r_v);
  assign w_valida = eh_um_quente(r_v);

  // A value is stable once it has been sampled unchanged for ESTAVEL cycles
  // inside the current state.
  assign w_estavel     = w_cnt_cheio && !w_mudou;
  assign w_clr_estavel = (w_prox != r_estado) || w_mudou;

  contador_sat #(
    .MAX (ESTAVEL - 1)
  ) u_cnt_estavel (
    .clock   (clock),
    .reset   (reset),
    .i_clr   (w_clr_estavel),
    .i_en    (1'b1),
    .o_cheio (w_cnt_cheio)
  );

  always_comb begin
    w_prox    = r_estado;
    w_dispara = 1'b0;
    case (r_estado)
      OCIOSO: begin
        if (w_tem) w_prox = bus.habilita ? FILTRANDO : SOLTANDO;
      end
      FILTRANDO: begin
        if (!w_tem) begin
          w_prox = OCIOSO;
        end else if (!bus.habilita) begin
          w_prox = SOLTANDO;
        end else if (w_estavel) begin
          w_prox    = PRESSIONADO;
          w_dispara = 1'b1;
        end
      end
      PRESSIONADO: begin
        if (!w_tem) w_prox = SOLTANDO;
      end
      SOLTANDO: begin
        if (w_tem) begin
          w_prox = PRESSIONADO;
        end else if (w_estavel) begin
          w_prox = OCIOSO;
        end
      end
      default: w_prox = OCIOSO;
    endcase
  end

  // r_v follows botoes every cycle, so at the accepting edge it equals the stable value.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado   <= OCIOSO;
      r_v        <= '0;
      r_jogada   <= '0;
      r_feita    <= 1'b0;
      r_invalida <= 1'b0;
    end else begin
      r_estado   <= w_prox;
      r_v        <= bus.botoes;
      r_feita    <= w_dispara && w_valida;
      r_invalida <= w_dispara && !w_valida;
      if (w_dispara && w_valida) r_jogada <= r_v;
    end
  end

`ifdef DETECTOR_TIMEOUT_EN
  logic w_zera;
  logic w_clr_ocioso;
  logic w_en_ocioso;
  logic w_ocioso_cheio;
  logic r_timeout;

  assign w_zera       = bus.zera_timeout || !bus.habilita;
  assign w_clr_ocioso = w_zera || ((w_prox == PRESSIONADO) && (r_estado != PRESSIONADO));
  assign w_en_ocioso  = bus.habilita && ((r_estado == OCIOSO) || (r_estado == SOLTANDO));

  contador_sat #(
    .MAX (TIMEOUT - 1)
  ) u_cnt_ocioso (
    .clock   (clock),
    .reset   (reset),
    .i_clr   (w_clr_ocioso),
    .i_en    (w_en_ocioso),
    .o_cheio (w_ocioso_cheio)
  );

  // Flag survives the counter being cleared by a press; only an explicit clear drops it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_timeout <= 1'b0;
    end else if (w_zera) begin
      r_timeout <= 1'b0;
    end else if (w_ocioso_cheio) begin
      r_timeout <= 1'b1;
    end
  end

  assign bus.timeout = r_timeout;
`else
  logic w_unused_zera;
  assign w_unused_zera = bus.zera_timeout;
  assign bus.timeout   = 1'b0;
`endif

  assign bus.jogada_feita    = r_feita;
  assign bus.jogada          = r_jogada;
  assign bus.jogada_invalida = r_invalida;
  assign bus.db_tem_jogada   = w_tem;
  assign bus.db_estado       = r_estado;

endmodule

// File: tb/tb_detector_jogada.sv
// Bench for detector_jogada: directed play scenarios followed by random
// button activity, all checked against a cycle-level behavioural model.
`timescale 1us/1ns
module tb_detector_jogada;

  localparam int ESTAVEL = 3;
  localparam int TIMEOUT = 20;
`ifdef DETECTOR_TIMEOUT_EN
  localparam logic TO_EN = 1'b1;
`else
  localparam logic TO_EN = 1'b0;
`endif

  localparam int F_OCIOSO = 0;
  localparam int F_FILT   = 1;
  localparam int F_PRESS  = 2;
  localparam int F_SOLT   = 3;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #50 clock = ~clock;

  detector_jogada_if bus();

  detector_jogada #(
    .ESTAVEL (ESTAVEL),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_falhas = 0;
  int n_feita  = 0;
  int n_inval  = 0;

  // Model state: phase, cycles spent in phase, run length of current botoes value.
  int         m_fase, m_idade, m_run, m_ocioso;
  logic [3:0] m_ult, m_jog;
  logic       m_feita, m_inval, m_to;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_falhas++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelo_reset();
    m_fase = F_OCIOSO; m_idade = 0; m_run = 1; m_ocioso = 0;
    m_ult = 4'd0; m_jog = 4'd0; m_feita = 1'b0; m_inval = 1'b0; m_to = 1'b0;
  endtask

  // One clock edge of the play rules, given the inputs held across that edge.
  task automatic modelo_passo(input logic [3:0] b, input logic hab, input logic zt);
    int   nxt;
    logic ev, est;
    if (b == m_ult) begin
      if (m_run < 1000) m_run++;
    end else begin
      m_run = 1;
    end
    m_ult = b;
    est = (m_run >= ESTAVEL + 1) && (m_idade + 1 >= ESTAVEL);
    nxt = m_fase;
    ev  = 1'b0;
    case (m_fase)
      F_OCIOSO: if (b != 0) nxt = hab ? F_FILT : F_SOLT;
      F_FILT: begin
        if (b == 0)    nxt = F_OCIOSO;
        else if (!hab) nxt = F_SOLT;
        else if (est) begin nxt = F_PRESS; ev = 1'b1; end
      end
      F_PRESS: if (b == 0) nxt = F_SOLT;
      F_SOLT: begin
        if (b != 0)   nxt = F_PRESS;
        else if (est) nxt = F_OCIOSO;
      end
      default: nxt = F_OCIOSO;
    endcase
    if (TO_EN) begin
      if (zt || !hab) m_to = 1'b0;
      else if (m_ocioso == TIMEOUT - 1) m_to = 1'b1;
      if (zt || !hab || (nxt == F_PRESS && m_fase != F_PRESS)) m_ocioso = 0;
      else if ((m_fase == F_OCIOSO || m_fase == F_SOLT) && m_ocioso < TIMEOUT - 1) m_ocioso++;
    end
    m_feita = ev && ($countones(b) == 1);
    m_inval = ev && ($countones(b) > 1);
    if (m_feita) m_jog = b;
    if (nxt != m_fase) m_idade = 0;
    else if (m_idade < 1000) m_idade++;
    m_fase = nxt;
  endtask

  // Drive inputs for one cycle (called just after a falling edge) and check.
  task automatic ciclo(input logic [3:0] b, input logic hab, input logic zt);
    bus.botoes = b; bus.habilita = hab; bus.zera_timeout = zt;
    modelo_passo(b, hab, zt);
    @(posedge clock);
    @(negedge clock);
    check("jogada_feita",    32'(bus.jogada_feita),    32'(m_feita));
    check("jogada_invalida", 32'(bus.jogada_invalida), 32'(m_inval));
    check("jogada",          32'(bus.jogada),          32'(m_jog));
    check("timeout",         32'(bus.timeout),         32'(m_to));
    check("db_estado",       32'(bus.db_estado),       32'(m_fase));
    check("db_tem_jogada",   32'(bus.db_tem_jogada),   32'(b != 4'd0));
    check("pulsos_exclusivos", 32'(bus.jogada_feita & bus.jogada_invalida), 32'd0);
    if (bus.jogada_feita)    n_feita++;
    if (bus.jogada_invalida) n_inval++;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         lat;
    logic [3:0] b;
    logic       hab;
    int         hold, rel;

    bus.botoes = 4'd0; bus.habilita = 1'b0; bus.zera_timeout = 1'b0;
    modelo_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    check("reset_estado", 32'(bus.db_estado), 32'd0);
    check("reset_jogada", 32'(bus.jogada),    32'd0);
    check("reset_timeout", 32'(bus.timeout),  32'd0);

    // Clean one-hot press and release.
    n_feita = 0; lat = 0;
    for (int i = 0; i < 10; i++) begin
      ciclo(4'b0100, 1'b1, 1'b0);
      if (bus.jogada_feita && lat == 0) lat = i + 1;
    end
    repeat (10) ciclo(4'b0000, 1'b1, 1'b0);
    check("latencia",       32'(lat),           32'(ESTAVEL + 1));
    check("um_evento",      32'(n_feita),       32'd1);
    check("jogada_0100",    32'(bus.jogada),    32'h4);
    check("volta_ocioso",   32'(bus.db_estado), 32'd0);

    // Press shorter than the filter window.
    n_feita = 0;
    repeat (2) ciclo(4'b0010, 1'b1, 1'b0);
    repeat (5) ciclo(4'b0000, 1'b1, 1'b0);
    check("curto_sem_evento", 32'(n_feita),       32'd0);
    check("curto_ocioso",     32'(bus.db_estado), 32'd0);

    // Multi-hot press.
    n_feita = 0; n_inval = 0;
    repeat (10) ciclo(4'b0101, 1'b1, 1'b0);
    repeat (10) ciclo(4'b0000, 1'b1, 1'b0);
    check("invalida_uma",    32'(n_inval),    32'd1);
    check("invalida_sem_ok", 32'(n_feita),    32'd0);
    check("jogada_mantida",  32'(bus.jogada), 32'h4);

    // Asynchronous reset in the middle of filtering.
    repeat (2) ciclo(4'b0001, 1'b1, 1'b0);
    check("pre_reset_filtrando", 32'(bus.db_estado), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("async_estado",   32'(bus.db_estado),       32'd0);
    check("async_jogada",   32'(bus.jogada),          32'd0);
    check("async_feita",    32'(bus.jogada_feita),    32'd0);
    check("async_invalida", 32'(bus.jogada_invalida), 32'd0);
    check("async_timeout",  32'(bus.timeout),         32'd0);
    @(negedge clock);
    bus.botoes = 4'd0;
    reset = 1'b1;
    modelo_reset();

    // Idle timeout.
    ciclo(4'b0000, 1'b1, 1'b1);
    repeat (TIMEOUT - 1) ciclo(4'b0000, 1'b1, 1'b0);
    check("timeout_antes", 32'(bus.timeout), 32'd0);
    ciclo(4'b0000, 1'b1, 1'b0);
    check("timeout_limite", 32'(bus.timeout), 32'(TO_EN));
    repeat (5) ciclo(4'b0000, 1'b1, 1'b0);
    check("timeout_mantido", 32'(bus.timeout), 32'(TO_EN));
    ciclo(4'b0000, 1'b1, 1'b1);
    check("timeout_zerado", 32'(bus.timeout), 32'd0);

    // Press made while disabled must be released before it can count.
    n_feita = 0;
    repeat (3) ciclo(4'b1000, 1'b0, 1'b0);
    repeat (5) ciclo(4'b1000, 1'b1, 1'b0);
    repeat (6) ciclo(4'b0000, 1'b1, 1'b0);
    check("desabilitado_sem_evento", 32'(n_feita), 32'd0);
    repeat (6) ciclo(4'b1000, 1'b1, 1'b0);
    check("nova_press_evento", 32'(n_feita),    32'd1);
    check("jogada_1000",       32'(bus.jogada), 32'h8);
    repeat (6) ciclo(4'b0000, 1'b1, 1'b0);

    // Random press/release episodes.
    for (int ep = 0; ep < 80; ep++) begin
      hab = ($urandom_range(0, 9) != 0);
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: b = 4'(1 << $urandom_range(0, 3));
        6, 7: begin
          b = 4'($urandom_range(3, 15));
          while ($countones(b) < 2) b = 4'($urandom_range(3, 15));
        end
        default: b = 4'd0;
      endcase
      hold = $urandom_range(1, 7);
      for (int k = 0; k < hold; k++) begin
        if (k == hold / 2 && $urandom_range(0, 4) == 0) b = 4'($urandom_range(1, 15));
        if ($urandom_range(0, 11) == 0) hab = ~hab;
        ciclo(b, hab, $urandom_range(0, 15) == 0);
      end
      rel = $urandom_range(1, 8);
      for (int k = 0; k < rel; k++) begin
        if ($urandom_range(0, 11) == 0) hab = ~hab;
        ciclo(4'd0, hab, $urandom_range(0, 15) == 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_falhas);
    $finish;
  end

endmodule
